// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: skid FSM states and per-stage payload layouts.
// Stage payload widths are exported so each pipe_stage_reg instance can size DATA_W from its struct.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [15:0] ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [15:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [31:0] alu_res;
        logic [31:0] store_dat;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] result;
        logic [4:0]  rd;
    } mem_wb_t;

    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Entries held for a given state; FULL is the only two-entry state.
    function automatic logic [1:0] occ_of(input stage_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_perf_ctr.sv
// Saturating stall / flush-hit counters for a pipeline stage; only built with PIPE_STAGE_PERF_EN.
// One-cycle update latency; counters never wrap and clear on synchronous rst.
module pipe_stage_reg_perf_ctr
#(
    parameter int STALL_W = 32,
    parameter int FLUSH_W = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stall,
    input  logic               i_flush_hit,
    output logic [STALL_W-1:0] o_stall_cnt,
    output logic [FLUSH_W-1:0] o_flush_cnt
);

    logic [STALL_W-1:0] r_stall_cnt;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic               w_stall_sat;
    logic               w_flush_sat;

    assign w_stall_sat = &r_stall_cnt;
    assign w_flush_sat = &r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall && !w_stall_sat)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (i_flush_hit && !w_flush_sat)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with 2-entry skid; 1-cycle latency, registered in_ready, flush kills all.
// Optional perf counters (stall_cnt, flush_cnt) are present only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W         = 160,
    parameter bit                 CLEAR_ON_FLUSH = 1'b1,
    parameter logic [DATA_W-1:0]  RESET_DATA     = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic              r_in_rdy;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_acc;
    logic              w_pop;

    assign w_acc = in_valid & r_in_rdy;
    assign w_pop = (r_state != EMPTY) & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_acc) w_state_nxt = ONE;
            ONE: begin
                if (w_acc && !w_pop)
                    w_state_nxt = FULL;
                else if (!w_acc && w_pop)
                    w_state_nxt = EMPTY;
            end
            FULL:    if (w_pop) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
        if (flush)
            w_state_nxt = EMPTY;
    end

    // in_ready is precomputed from the next state so the upstream stall path starts at a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b1;
            r_main   <= RESET_DATA;
            r_skid   <= RESET_DATA;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != FULL);
            if (flush) begin
                if (CLEAR_ON_FLUSH) begin
                    r_main <= RESET_DATA;
                    r_skid <= RESET_DATA;
                end
            end else begin
                case (r_state)
                    EMPTY: if (w_acc) r_main <= in_data;
                    ONE: begin
                        if (w_acc && w_pop)
                            r_main <= in_data;
                        else if (w_acc)
                            r_skid <= in_data;
                    end
                    FULL:    if (w_pop) r_main <= r_skid;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occ       = occ_of(r_state);

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_reg_perf_ctr #(
        .STALL_W (32),
        .FLUSH_W (16)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (out_valid & ~out_ready),
        .i_flush_hit (flush & (r_state != EMPTY)),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg handshake, skid ordering, flush and reset.
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam logic [DW-1:0] RST_VAL = 160'h5A5A_0000_0000_0000_0000_0000_0000_0000_0000_C3C3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [15:0]   flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(
        .DATA_W         (DW),
        .CLEAR_ON_FLUSH (1'b1),
        .RESET_DATA     (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic ov, input logic ir, input logic [1:0] oc);
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
        chk({tag, ".in_ready"},  DW'(in_ready),  DW'(ir));
        chk({tag, ".occ"},       DW'(occ),       DW'(oc));
    endtask

    logic [DW-1:0] q[$];
    logic          acc;
    logic          pop;
    logic [31:0]   seq;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        chk_ctl("reset", 1'b0, 1'b1, 2'd0);
        chk("reset.out_data", out_data, RST_VAL);

        // 1: streaming, one result per cycle, occupancy pinned at 1
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
            chk_ctl($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
            chk($sformatf("stream%0d.data", i), out_data, DW'(i));
        end
        in_valid = 1'b0;
        step();
        chk_ctl("stream_drain", 1'b0, 1'b1, 2'd0);
        chk("stream_drain.hold", out_data, DW'(8));

        // 2: downstream stall fills the skid, then releases in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('hA);
        step();
        chk_ctl("stall_a", 1'b1, 1'b1, 2'd1);
        chk("stall_a.data", out_data, DW'('hA));
        in_data = DW'('hB);
        step();
        chk_ctl("stall_b", 1'b1, 1'b0, 2'd2);
        chk("stall_b.data", out_data, DW'('hA));
        in_data = DW'('hC);
        step();
        chk_ctl("stall_c_held", 1'b1, 1'b0, 2'd2);
        chk("stall_c_held.data", out_data, DW'('hA));
        out_ready = 1'b1;
        step();
        chk_ctl("release_b", 1'b1, 1'b1, 2'd1);
        chk("release_b.data", out_data, DW'('hB));
        step();
        chk_ctl("release_c", 1'b1, 1'b1, 2'd1);
        chk("release_c.data", out_data, DW'('hC));
        in_valid = 1'b0;
        step();
        chk_ctl("release_empty", 1'b0, 1'b1, 2'd0);

        // 3: flush while FULL with a fresh offer; offer is dropped, payload cleared
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(1);
        step();
        in_data = DW'(2);
        step();
        chk("pre_flush.occ", DW'(occ), DW'(2));
        in_data = DW'('hD); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_ctl("flush_full", 1'b0, 1'b1, 2'd0);
        chk("flush_full.data", out_data, RST_VAL);
        out_ready = 1'b1;
        step();
        chk_ctl("flush_no_d", 1'b0, 1'b1, 2'd0);
        chk("flush_no_d.data", out_data, RST_VAL);

        // flush in ONE also wins over a simultaneous accept and pop
        in_valid = 1'b1; in_data = DW'('h11);
        step();
        in_data = DW'('h22); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_ctl("flush_one", 1'b0, 1'b1, 2'd0);
        chk("flush_one.data", out_data, RST_VAL);

        // 4: reset mid-stall with flush also asserted
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(3);
        step();
        in_data = DW'(4);
        step();
        chk("pre_rst.occ", DW'(occ), DW'(2));
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk_ctl("rst_stall", 1'b0, 1'b1, 2'd0);
        chk("rst_stall.data", out_data, RST_VAL);

        // 5: random handshake against a FIFO model
        q.delete();
        seq = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            chk("rand.occ", DW'(occ), DW'(q.size()));
            chk("rand.valid", DW'(out_valid), DW'(q.size() != 0));
            chk("rand.ready", DW'(in_ready), DW'(q.size() < 2));
            if (q.size() != 0)
                chk("rand.data", out_data, q[0]);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            seq       = seq + 32'd1;
            in_data   = {seq, 96'd0, $urandom()};
            acc = in_valid & (q.size() < 2);
            pop = out_ready & (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        chk_ctl("rand_drain", 1'b0, 1'b1, 2'd0);

`ifdef PIPE_STAGE_PERF_EN
        // 6: counter behaviour
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('h77);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf.stall_cnt", DW'(stall_cnt), DW'(5));
        chk("perf.flush_cnt", DW'(flush_cnt), DW'(1));
        force dut.u_perf.r_stall_cnt = 32'hFFFF_FFFF;
        step();
        release dut.u_perf.r_stall_cnt;
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("perf.stall_sat", DW'(stall_cnt), DW'(32'hFFFF_FFFF));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
